// File: rtl/box_seq_pkg.sv
// Shared types and constants for the bouncing-box draw sequencer.
package box_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_DRAW
    } state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int POS_Y_RST    = 60;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick divider and frame counter; step pulses once every MOVE_FRAMES frames.
module frame_tick_gen #(
    parameter int FRAME_DIV   = 833333,
    parameter int MOVE_FRAMES = 15
) (
    input  logic clk,
    input  logic resetn,
    output logic step
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FW = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

    logic [CW-1:0] cyc_q, cyc_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          frame_tick;

    always_comb begin
        frame_tick = (cyc_q == CW'(FRAME_DIV - 1));
        cyc_d      = frame_tick ? '0 : cyc_q + 1'b1;
        frm_d      = frm_q;
        step       = 1'b0;
        if (frame_tick) begin
            if (frm_q == FW'(MOVE_FRAMES - 1)) begin
                frm_d = '0;
                step  = 1'b1;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_q <= '0;
            frm_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            frm_q <= frm_d;
        end
    end

endmodule

// File: rtl/box_draw_sequencer.sv
// Bouncing-box animator driving a VGA pixel-write port.
// Define BOX_SEQ_ERASE_EN to erase the old box before each move; otherwise the box leaves a trail.
module box_draw_sequencer
    import box_seq_pkg::*;
#(
    parameter int FRAME_DIV   = 833333,
    parameter int MOVE_FRAMES = 15,
    parameter int BOX_SIZE    = 4,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [2:0] colour_in,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy
);

    localparam int MAX_X = SCREEN_W - BOX_SIZE;
    localparam int MAX_Y = SCREEN_H - BOX_SIZE;
    localparam int BW    = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;

    // Returns {new_dir, new_pos}; a wall hit reverses and steps away in the same move.
    function automatic logic [8:0] axis_step(input logic [7:0] pos, input logic dir,
                                             input logic [7:0] max);
        if (dir && pos >= max)
            return {1'b0, max - 8'd1};
        else if (!dir && pos == 8'd0)
            return {1'b1, 8'd1};
        else if (dir)
            return {1'b1, pos + 8'd1};
        else
            return {1'b0, pos - 8'd1};
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      pos_x_q, pos_x_d;
    logic [7:0]      pos_y_q, pos_y_d;
    logic            x_dir_q, x_dir_d;
    logic            y_dir_q, y_dir_d;
    logic [2:0]      colour_q, colour_d;
    logic [BW-1:0]   col_q, col_d;
    logic [BW-1:0]   row_q, row_d;
    logic            pending_q, pending_d;
    logic [7:0]      x_out_q, x_out_d;
    logic [6:0]      y_out_q, y_out_d;
    logic [2:0]      colour_out_q, colour_out_d;
    logic            plot_q, plot_d;
    logic            busy_q, busy_d;
    logic            step;
    logic            last_col, last_px;

    frame_tick_gen #(
        .FRAME_DIV   (FRAME_DIV),
        .MOVE_FRAMES (MOVE_FRAMES)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .step   (step)
    );

    always_comb begin
        last_col     = (col_q == BW'(BOX_SIZE - 1));
        last_px      = last_col && (row_q == BW'(BOX_SIZE - 1));
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        x_dir_d      = x_dir_q;
        y_dir_d      = y_dir_q;
        colour_d     = colour_q;
        col_d        = col_q;
        row_d        = row_q;
        pending_d    = pending_q;
        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        colour_out_d = colour_out_q;

        // One-deep event memory while the sequence is busy; extra events are lost.
        if (step && state_q != S_WAIT)
            pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_INIT_DRAW;
                    colour_d = colour_in;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            S_INIT_DRAW, S_DRAW: begin
                col_d = last_col ? '0 : col_q + 1'b1;
                row_d = last_col ? row_q + 1'b1 : row_q;
                if (last_px)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                pending_d = 1'b0;
                if (!go) begin
                    state_d = S_IDLE;
                end else if (step || pending_q) begin
`ifdef BOX_SEQ_ERASE_EN
                    state_d = S_ERASE;
                    col_d   = '0;
                    row_d   = '0;
`else
                    state_d = S_MOVE;
`endif
                end
            end
`ifdef BOX_SEQ_ERASE_EN
            S_ERASE: begin
                col_d = last_col ? '0 : col_q + 1'b1;
                row_d = last_col ? row_q + 1'b1 : row_q;
                if (last_px)
                    state_d = S_MOVE;
            end
`endif
            S_MOVE: begin
                {x_dir_d, pos_x_d} = axis_step(pos_x_q, x_dir_q, 8'(MAX_X));
                {y_dir_d, pos_y_d} = axis_step(pos_y_q, y_dir_q, 8'(MAX_Y));
                colour_d = colour_in;
                col_d    = '0;
                row_d    = '0;
                state_d  = S_DRAW;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so plot aligns with the phase.
        plot_d = (state_d inside {S_INIT_DRAW, S_ERASE, S_DRAW});
        busy_d = !(state_d inside {S_IDLE, S_WAIT});
        if (plot_d) begin
            x_out_d      = pos_x_d + 8'(col_d);
            y_out_d      = 7'(pos_y_d + 8'(row_d));
            colour_out_d = colour_d;
`ifdef BOX_SEQ_ERASE_EN
            if (state_d == S_ERASE)
                colour_out_d = COLOUR_BLACK;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pos_x_q      <= '0;
            pos_y_q      <= 8'(POS_Y_RST);
            x_dir_q      <= 1'b1;
            y_dir_q      <= 1'b1;
            colour_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pending_q    <= 1'b0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            colour_out_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            x_dir_q      <= x_dir_d;
            y_dir_q      <= y_dir_d;
            colour_q     <= colour_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pending_q    <= pending_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            colour_out_q <= colour_out_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
        end
    end

    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign colour_out = colour_out_q;
    assign plot       = plot_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_box_draw_sequencer.sv
// Scoreboard bench for box_draw_sequencer; expectations follow BOX_SEQ_ERASE_EN.
module tb_box_draw_sequencer;

    localparam int FD = 4;
    localparam int MF = 2;
    localparam int BS = 4;
    // A narrow/short screen puts a corner at (4,64), reachable in four moves from (0,60).
    localparam int SW = 8;
    localparam int SH = 68;
`ifdef BOX_SEQ_ERASE_EN
    localparam bit ERASE_ON = 1'b1;
    localparam int EXP_GAP  = 1;
`else
    localparam bit ERASE_ON = 1'b0;
    localparam int EXP_GAP  = 2;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic [2:0] colour_in = 3'b000;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;

    always #5 clk = ~clk;

    box_draw_sequencer #(
        .FRAME_DIV   (FD),
        .MOVE_FRAMES (MF),
        .BOX_SIZE    (BS),
        .SCREEN_W    (SW),
        .SCREEN_H    (SH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .colour_in  (colour_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    px_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  burst_starts = 0;
    int  seg = 0;

    // Hand-computed box origins after each move: up-right to the corner, then back.
    int tab_x [0:8] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    int tab_y [0:8] = '{60, 61, 62, 63, 64, 63, 62, 61, 60};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_box(input int x, input int y, input logic [2:0] c);
        for (int r = 0; r < BS; r++)
            for (int cc = 0; cc < BS; cc++)
                exp_q.push_back('{x: 8'(x + cc), y: 7'(y + r), c: c});
    endtask

    task automatic push_step(input int k, input logic [2:0] c);
        if (ERASE_ON)
            push_box(tab_x[k-1], tab_y[k-1], 3'b000);
        push_box(tab_x[k], tab_y[k], c);
    endtask

    task automatic wait_bursts(input int target, input int budget, input string what);
        int n = 0;
        while (burst_starts < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (burst_starts < target) begin
            errors++;
            $display("FAIL timeout_%s: bursts %0d required %0d", what, burst_starts, target);
        end
    endtask

    task automatic wait_drain(input int budget, input string what);
        int n = 0;
        while ((exp_q.size() != 0 || plot) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || plot) begin
            errors++;
            $display("FAIL drain_%s: %0d pixels still expected", what, exp_q.size());
        end
    endtask

    // Monitor: pops one expected pixel per plot cycle, checks burst length and inter-burst gap.
    bit in_burst = 1'b0;
    bit have_prev = 1'b0;
    int blen = 0;
    int gap = 0;
    int prev_seg = -1;

    always @(negedge clk) begin
        px_t e;
        if (!resetn) begin
            in_burst  = 1'b0;
            have_prev = 1'b0;
        end else if (plot) begin
            if (!in_burst) begin
                burst_starts++;
                if (have_prev && prev_seg == seg)
                    check("burst_gap", gap, EXP_GAP);
                in_burst = 1'b1;
                blen = 0;
            end
            blen++;
            check("busy_while_plot", int'(busy), 1);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%0d with no pixel expected",
                         x_out, y_out, colour_out);
            end else begin
                e = exp_q.pop_front();
                if (x_out !== e.x || y_out !== e.y || colour_out !== e.c) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                             x_out, y_out, colour_out, e.x, e.y, e.c);
                end
            end
        end else begin
            if (in_burst) begin
                check("burst_len", blen, BS * BS);
                in_burst  = 1'b0;
                have_prev = 1'b1;
                prev_seg  = seg;
                gap       = 1;
            end else begin
                gap++;
            end
        end
    end

    initial begin
        int base;

        resetn = 1'b0;
        go = 1'b0;
        colour_in = 3'b101;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x_out", int'(x_out), 0);
        check("rst_y_out", int'(y_out), 0);
        check("rst_colour_out", int'(colour_out), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);

        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_plot", int'(plot), 0);
        check("idle_busy", int'(busy), 0);

        // Segment 1: initial box, six moves through the corner, go drops mid-sequence.
        base = burst_starts;
        push_box(tab_x[0], tab_y[0], 3'b101);
        for (int k = 1; k <= 6; k++)
            push_step(k, 3'b101);
        seg = 1;
        go = 1'b1;
        wait_bursts(base + (ERASE_ON ? 12 : 7), 2000, "seg1");
        repeat (5) @(posedge clk);
        #1;
        go = 1'b0;
        wait_drain(500, "seg1");
        repeat (3) @(posedge clk);
        #1;
        check("stop_busy", int'(busy), 0);
        repeat (40) @(posedge clk);
        #1;
        check("stop_busy_late", int'(busy), 0);
        check("stop_plot_late", int'(plot), 0);

        // Segment 2: restart at the held position with a new colour, reset mid-draw.
        colour_in = 3'b011;
        base = burst_starts;
        push_box(tab_x[6], tab_y[6], 3'b011);
        push_step(7, 3'b011);
        seg = 2;
        go = 1'b1;
        wait_bursts(base + (ERASE_ON ? 3 : 2), 500, "seg2");
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_plot", int'(plot), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_x_out", int'(x_out), 0);
        check("midrst_y_out", int'(y_out), 0);
        check("midrst_colour_out", int'(colour_out), 0);
        go = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Segment 3: position and direction are back at reset values.
        colour_in = 3'b110;
        base = burst_starts;
        push_box(tab_x[0], tab_y[0], 3'b110);
        push_step(1, 3'b110);
        seg = 3;
        go = 1'b1;
        wait_bursts(base + 2, 500, "seg3");
        repeat (3) @(posedge clk);
        #1;
        go = 1'b0;
        wait_drain(500, "seg3");
        repeat (20) @(posedge clk);
        #1;
        check("end_busy", int'(busy), 0);
        check("end_plot", int'(plot), 0);
        check("end_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/box_draw_sequencer.md
BOX_DRAW_SEQUENCER -- requirements
Module: box_draw_sequencer

Interface
REQ-001 Parameters SHALL be: FRAME_DIV, default 833333, clk cycles per 60 Hz frame; MOVE_FRAMES, default 15, frames per box step; BOX_SIZE, default 4, box edge in pixels; SCREEN_W, default 160; SCREEN_H, default 120.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 go  input  1  run enable: high starts or continues animation, low stops it after the current sequence.
REQ-005 colour_in  input  3  box colour, sampled once per step.
REQ-006 x_out  output  8  pixel x to the VGA adapter.
REQ-007 y_out  output  7  pixel y to the VGA adapter.
REQ-008 colour_out  output  3  pixel colour.
REQ-009 plot  output  1  pixel write strobe, one pixel per high cycle.
REQ-010 busy  output  1  high in any state other than IDLE and WAIT.

Function
REQ-011 The FSM SHALL have states IDLE, INIT_DRAW, WAIT, ERASE, MOVE and DRAW.
- IDLE->INIT_DRAW when go=1.
- INIT_DRAW->WAIT.
- WAIT->IDLE when go=0; otherwise WAIT->ERASE on a step event.
- ERASE->MOVE, MOVE->DRAW, DRAW->WAIT.
REQ-012 The tick generator SHALL count clk cycles 0..FRAME_DIV-1 and pulse frame_tick for 1 cycle at wrap; a frame counter 0..MOVE_FRAMES-1 SHALL advance per tick; a step event SHALL occur when the frame counter wraps.
REQ-013 Counters SHALL run in every state; a step event outside WAIT SHALL set a one-deep pending flag, consumed on the next WAIT cycle; further events while pending is set SHALL be dropped.
REQ-014 Each of ERASE, INIT_DRAW and DRAW SHALL last exactly BOX_SIZE*BOX_SIZE cycles, with plot=1 every cycle and pixel k on the registered outputs at x=pos_x+(k mod BOX_SIZE) and y=pos_y+(k div BOX_SIZE), raster order.
REQ-015 ERASE SHALL output colour 3'b000; INIT_DRAW and DRAW SHALL output the colour latched in MOVE (INIT_DRAW latches colour_in on entry).
REQ-016 plot SHALL be 0 in IDLE, WAIT and MOVE; MOVE SHALL last exactly 1 cycle.
REQ-017 In MOVE, per axis: if dir=1 and pos=max, or dir=0 and pos=0, the block SHALL flip dir and step pos one pixel in the new direction; otherwise it SHALL step pos +/-1 in dir. Here max_x=SCREEN_W-BOX_SIZE (156) and max_y=SCREEN_H-BOX_SIZE (116).
REQ-018 On a corner, both axes SHALL flip in the same MOVE cycle.
REQ-019 Position arithmetic SHALL never leave 0..max; x_out and y_out SHALL never exceed 159 and 119.
REQ-020 If go falls mid-sequence, the block SHALL finish through DRAW, then go WAIT->IDLE; the box stays drawn.

Reset
REQ-021 On resetn=0: state=IDLE, pos_x=0, pos_y=60, x_dir=1, y_dir=1, latched colour=0, counters=0, pending=0, x_out=0, y_out=0, colour_out=0, plot=0, busy=0.
REQ-022 Reset asserted mid-phase SHALL abort the phase immediately; the partial box remains on screen.

Configuration
REQ-023 With macro BOX_SEQ_ERASE_EN defined, the ERASE phase SHALL run as specified.
REQ-024 Without BOX_SEQ_ERASE_EN, WAIT SHALL go directly to MOVE on a step event, producing a trail, and ERASE logic SHALL not be synthesised.

Structure
REQ-025 Package box_seq_pkg SHALL hold the FSM state enum, SCREEN_W/SCREEN_H defaults and the black colour constant.
REQ-026 The tick/frame counters SHALL be sub-module frame_tick_gen (ports clk, resetn, step).

Verification (FRAME_DIV=4, MOVE_FRAMES=2, BOX_SIZE=4, macro defined unless noted)
REQ-027 Reset then go=1 -> 16 plot cycles, pixels (0,60)..(3,63), colour=colour_in; then busy=0.
REQ-028 First step -> 16 black pixels at (0,60), then 1 MOVE cycle, then 16 pixels at (1,61)..(4,64).
REQ-029 Preload pos (156,116), dirs 1/1 -> after MOVE pos=(155,115), dirs 0/0.
REQ-030 Step event during DRAW -> pending set; ERASE starts the first WAIT cycle after DRAW; a second event in the same busy window is dropped.
REQ-031 go=0 mid-ERASE -> MOVE and DRAW complete, then IDLE, plot=0; resetn=0 mid-DRAW -> plot=0 and all REQ-021 values on the next edge.
REQ-032 Macro undefined -> no black pixels ever, MOVE directly after WAIT, 16 plot cycles per step.
